fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and hazard unit for the pipelined MIPS datapath. It replaces the fixed two-operand forwarding logic with:
- per-operand forwarding for NUM_SRC EX-stage operands, with register-zero exclusion;
- load-use stall detection;
- a scoreboard for one outstanding multi-cycle (mul/div) operation.

It sits beside the ID/EX pipeline register. It drives the EX operand muxes, the PC/IF-ID write enables (via stall) and the ID/EX bubble insert.

## Interface
- NUM_SRC, 2: number of EX-stage source operands checked for forwarding
- REG_AW, 5: register address width
- LAT_MAX, 4: maximum long-op latency in cycles (≥1)
- CNT_W, 16: stall performance counter width
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- ex_src  in  NUM_SRC*REG_AW  EX operand register addresses; operand i at bits [i*REG_AW +: REG_AW]
- m_regwrite, m_wr  in  1, REG_AW  MEM-stage write enable and destination
- wb_regwrite, wb_wr  in  1, REG_AW  WB-stage write enable and destination
- id_rs, id_rt  in  REG_AW each  ID-stage source addresses
- id_uses_rt  in  1  ID instruction reads rt
- id_long  in  1  ID instruction is a long op
- ex_mem_read, ex_wr  in  1, REG_AW  EX instruction is a load, and its destination
- ex_long_valid  in  1  long op issuing from EX this cycle
- ex_long_wr  in  REG_AW  long-op destination
- ex_long_lat  in  $clog2(LAT_MAX+1)  long-op latency
- fwd_en  out  NUM_SRC  operand i takes a forwarded value
- fwd_sel  out  NUM_SRC  per operand: 0 = MEM value, 1 = WB value
- stall  out  1  hold PC and IF/ID
- bubble  out  1  insert NOP into ID/EX (equals stall)
- long_busy  out  1  scoreboard occupied
- long_done  out  1  one-cycle pulse: long result valid on the write-back path
- long_err  out  1  sticky: issue attempted while busy
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation

**Forwarding (combinational, per operand i)**
- Let s = ex_src[i].
- MEM match: m_regwrite && m_wr==s && s!=0.
- WB match: wb_regwrite && wb_wr==s && s!=0.
- fwd_en[i] = MEM match | WB match.
- fwd_sel[i] = !MEM match && WB match. MEM has priority over WB.
- s==0 never forwards.

**Load-use stall**
- Condition: ex_mem_read && ex_wr!=0 && (ex_wr==id_rs || (id_uses_rt && ex_wr==id_rt)).
- Lasts one cycle. It clears naturally once the bubble enters EX.

**Scoreboard FSM**
- IDLE:
  - on ex_long_valid, capture pend_wr = ex_long_wr;
  - load cnt with the effective latency: ex_long_lat, with 0 treated as 1 and values above LAT_MAX clamped to LAT_MAX;
  - go to BUSY.
- BUSY:
  - if cnt==1, go to DONE;
  - otherwise decrement cnt.
- DONE:
  - long_done=1 for one cycle;
  - clear pend_wr and cnt;
  - go to IDLE.
  - A new ex_long_valid in DONE is accepted, exactly as in IDLE (next state BUSY).
- ex_long_valid in BUSY:
  - ignored, state unchanged;
  - long_err set; it stays set until reset.

**Outputs**
- long_busy = (state==BUSY).
- Scoreboard stall, asserted in BUSY only, when either:
  - pend_wr!=0 and (pend_wr==id_rs || (id_uses_rt && pend_wr==id_rt)); or
  - id_long (structural stall).
- DONE raises no stall: the register file is write-before-read.
- stall = load-use stall | scoreboard stall.
- bubble = stall.

**stall_cnt**
- Increments on every cycle with stall=1.
- Saturates at all ones.

## Timing
- Forwarding, stall and bubble are combinational from current inputs and state; there is no register on the output.
- Long op sampled at edge T with effective latency L:
  - long_busy=1 for cycles T+1 .. T+L;
  - long_done=1 in cycle T+L+1;
  - IDLE from T+L+2, unless a new op is accepted in DONE.
- Reset (rst=0, any time, including mid-BUSY):
  - state=IDLE, pend_wr=0, cnt=0;
  - long_err=0, stall_cnt=0;
  - long_busy=0, long_done=0.
  - Combinational outputs follow their inputs while in reset.
- After rst deasserts, the first edge may accept an issue.

## Structure
- Package fwd_hazard_pkg holds:
  - state enum: IDLE, BUSY, DONE;
  - fwd_sel encodings: SEL_MEM=0, SEL_WB=1;
  - REG_ZERO constant.
- One sub-module, fwd_sel_cell: one operand's MEM/WB compare and priority.
  - Instantiate NUM_SRC times with generate.
- The scoreboard FSM, counter and stall logic stay in the top level.

## Test plan
- ex_src0=5, m_regwrite=1, m_wr=5, wb_regwrite=1, wb_wr=5 -> fwd_en[0]=1, fwd_sel[0]=0. Then m_regwrite=0 -> fwd_sel[0]=1.
- ex_src1=0, m_wr=0, m_regwrite=1 -> fwd_en[1]=0.
- ex_mem_read=1, ex_wr=8, id_rt=8:
  - id_uses_rt=1 -> stall=bubble=1 for exactly one cycle; stall_cnt +1.
  - id_uses_rt=0 -> stall=0.
- ex_long_valid at T, ex_long_wr=9, ex_long_lat=3; id_rs=9 held:
  - long_busy for T+1..T+3;
  - stall=1 for T+1..T+3 (3 cycles);
  - long_done at T+4 with stall=0.
- ex_long_lat=0 -> 1 BUSY cycle. ex_long_lat=7 with LAT_MAX=4 -> 4 BUSY cycles.
- Second ex_long_valid mid-BUSY -> ignored, long_err=1 and sticky.
- rst pulsed low during BUSY -> long_busy=0, long_err=0, stall_cnt=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/fwd_hazard_pkg.sv
// fwd_hazard_pkg: shared types and constants for the forwarding/hazard unit.
//   lh_state_t : long-op scoreboard states
//   SEL_MEM/WB : fwd_sel encodings (operand source when forwarding)
//   REG_ZERO   : architectural zero register, never forwarded or tracked
package fwd_hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lh_state_t;

  localparam logic SEL_MEM = 1'b0;
  localparam logic SEL_WB  = 1'b1;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/fwd_sel_cell.sv
// fwd_sel_cell: forwarding decision for one EX-stage source operand.
//   i_src                     operand register address
//   i_m_regwrite, i_m_wr      MEM-stage write enable / destination
//   i_wb_regwrite, i_wb_wr    WB-stage write enable / destination
//   o_fwd_en                  operand takes a forwarded value
//   o_fwd_sel                 SEL_MEM or SEL_WB (MEM wins when both match)
module fwd_sel_cell
  import fwd_hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_m_regwrite,
  input  logic [REG_AW-1:0] i_m_wr,
  input  logic              i_wb_regwrite,
  input  logic [REG_AW-1:0] i_wb_wr,
  output logic              o_fwd_en,
  output logic              o_fwd_sel
);

  localparam logic [REG_AW-1:0] REG_Z = REG_AW'(REG_ZERO);

  logic w_src_nz;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_src_nz  = (i_src != REG_Z);
  assign w_mem_hit = i_m_regwrite  && (i_m_wr  == i_src) && w_src_nz;
  assign w_wb_hit  = i_wb_regwrite && (i_wb_wr == i_src) && w_src_nz;

  assign o_fwd_en  = w_mem_hit | w_wb_hit;
  // MEM holds the younger result, so it shadows a WB match on the same register
  assign o_fwd_sel = (!w_mem_hit && w_wb_hit) ? SEL_WB : SEL_MEM;

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding, load-use stall detection and a
// single-entry scoreboard for one outstanding multi-cycle (mul/div) op.
//   clk, rst (async, active-low)
//   ex_src                    NUM_SRC packed EX operand addresses
//   m_*/wb_*                  MEM/WB write-back candidates for forwarding
//   id_rs, id_rt, id_uses_rt  ID-stage sources
//   id_long                   ID instruction is itself a long op
//   ex_mem_read, ex_wr        EX load and its destination
//   ex_long_valid/_wr/_lat    long-op issue from EX
//   fwd_en, fwd_sel           per-operand forwarding controls
//   stall, bubble             hold PC/IF-ID and insert NOP into ID/EX
//   long_busy, long_done      scoreboard occupied / result-ready pulse
//   long_err                  sticky: issue attempted while busy
//   stall_cnt                 saturating stall-cycle counter
//
// Scoreboard states:
//   state | meaning
//   IDLE  | no long op outstanding
//   BUSY  | long op in flight, r_cnt cycles left (incl. current)
//   DONE  | result on write-back path this cycle; can accept a new op
module fwd_hazard_unit
  import fwd_hazard_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int LAT_MAX = 4,
  parameter int CNT_W   = 16,
  localparam int LAT_W  = $clog2(LAT_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src,
  input  logic                      m_regwrite,
  input  logic [REG_AW-1:0]         m_wr,
  input  logic                      wb_regwrite,
  input  logic [REG_AW-1:0]         wb_wr,
  input  logic [REG_AW-1:0]         id_rs,
  input  logic [REG_AW-1:0]         id_rt,
  input  logic                      id_uses_rt,
  input  logic                      id_long,
  input  logic                      ex_mem_read,
  input  logic [REG_AW-1:0]         ex_wr,
  input  logic                      ex_long_valid,
  input  logic [REG_AW-1:0]         ex_long_wr,
  input  logic [LAT_W-1:0]          ex_long_lat,
  output logic [NUM_SRC-1:0]        fwd_en,
  output logic [NUM_SRC-1:0]        fwd_sel,
  output logic                      stall,
  output logic                      bubble,
  output logic                      long_busy,
  output logic                      long_done,
  output logic                      long_err,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam logic [REG_AW-1:0] REG_Z = REG_AW'(REG_ZERO);

  lh_state_t         r_state;
  logic [REG_AW-1:0] r_pend_wr;
  logic [LAT_W-1:0]  r_cnt;
  logic              r_long_busy;
  logic              r_long_done;
  logic              r_long_err;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic [LAT_W-1:0]  w_eff_lat;
  logic              w_load_use;
  logic              w_pend_hit;
  logic              w_sb_stall;
  logic              w_stall;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
    fwd_sel_cell #(.REG_AW(REG_AW)) u_cell (
      .i_src         (ex_src[gi*REG_AW +: REG_AW]),
      .i_m_regwrite  (m_regwrite),
      .i_m_wr        (m_wr),
      .i_wb_regwrite (wb_regwrite),
      .i_wb_wr       (wb_wr),
      .o_fwd_en      (fwd_en[gi]),
      .o_fwd_sel     (fwd_sel[gi])
    );
  end

  // Zero latency is meaningless for a counter that exits on 1; oversized
  // requests are clamped so the op still completes in bounded time.
  always_comb begin
    w_eff_lat = ex_long_lat;
    if (ex_long_lat == '0)
      w_eff_lat = LAT_W'(1);
    else if (ex_long_lat > LAT_W'(LAT_MAX))
      w_eff_lat = LAT_W'(LAT_MAX);
  end

  assign w_load_use = ex_mem_read && (ex_wr != REG_Z) &&
                      ((ex_wr == id_rs) || (id_uses_rt && (ex_wr == id_rt)));

  assign w_pend_hit = (r_pend_wr != REG_Z) &&
                      ((r_pend_wr == id_rs) || (id_uses_rt && (r_pend_wr == id_rt)));

  // DONE is excluded: the regfile writes before it is read in the same cycle
  assign w_sb_stall = (r_state == BUSY) && (w_pend_hit || id_long);

  assign w_stall   = w_load_use | w_sb_stall;
  assign stall     = w_stall;
  assign bubble    = w_stall;
  assign long_busy = r_long_busy;
  assign long_done = r_long_done;
  assign long_err  = r_long_err;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_pend_wr   <= '0;
      r_cnt       <= '0;
      r_long_busy <= 1'b0;
      r_long_done <= 1'b0;
      r_long_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ex_long_valid) begin
            r_state     <= BUSY;
            r_long_busy <= 1'b1;
            r_pend_wr   <= ex_long_wr;
            r_cnt       <= w_eff_lat;
          end
        end
        BUSY: begin
          if (ex_long_valid)
            r_long_err <= 1'b1;
          if (r_cnt == LAT_W'(1)) begin
            r_state     <= DONE;
            r_long_busy <= 1'b0;
            r_long_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt - LAT_W'(1);
          end
        end
        DONE: begin
          r_long_done <= 1'b0;
          if (ex_long_valid) begin
            r_state     <= BUSY;
            r_long_busy <= 1'b1;
            r_pend_wr   <= ex_long_wr;
            r_cnt       <= w_eff_lat;
          end else begin
            r_state   <= IDLE;
            r_pend_wr <= '0;
            r_cnt     <= '0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_long_busy <= 1'b0;
          r_long_done <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst;
  logic [9:0]  ex_src;
  logic        m_regwrite, wb_regwrite;
  logic [4:0]  m_wr, wb_wr, id_rs, id_rt, ex_wr, ex_long_wr;
  logic        id_uses_rt, id_long, ex_mem_read, ex_long_valid;
  logic [2:0]  ex_long_lat;
  logic [1:0]  fwd_en, fwd_sel;
  logic        stall, bubble, long_busy, long_done, long_err;
  logic [15:0] stall_cnt;
  logic [1:0]  s_fwd_en, s_fwd_sel;
  logic        s_stall, s_bubble, s_long_busy, s_long_done, s_long_err;
  logic [2:0]  s_stall_cnt;

  fwd_hazard_unit #(.NUM_SRC(2), .REG_AW(5), .LAT_MAX(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ex_src(ex_src),
    .m_regwrite(m_regwrite), .m_wr(m_wr), .wb_regwrite(wb_regwrite), .wb_wr(wb_wr),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_long(id_long),
    .ex_mem_read(ex_mem_read), .ex_wr(ex_wr), .ex_long_valid(ex_long_valid),
    .ex_long_wr(ex_long_wr), .ex_long_lat(ex_long_lat),
    .fwd_en(fwd_en), .fwd_sel(fwd_sel), .stall(stall), .bubble(bubble),
    .long_busy(long_busy), .long_done(long_done), .long_err(long_err),
    .stall_cnt(stall_cnt)
  );

  // narrow-counter copy to exercise saturation
  fwd_hazard_unit #(.NUM_SRC(2), .REG_AW(5), .LAT_MAX(4), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .ex_src(ex_src),
    .m_regwrite(m_regwrite), .m_wr(m_wr), .wb_regwrite(wb_regwrite), .wb_wr(wb_wr),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_long(id_long),
    .ex_mem_read(ex_mem_read), .ex_wr(ex_wr), .ex_long_valid(ex_long_valid),
    .ex_long_wr(ex_long_wr), .ex_long_lat(ex_long_lat),
    .fwd_en(s_fwd_en), .fwd_sel(s_fwd_sel), .stall(s_stall), .bubble(s_bubble),
    .long_busy(s_long_busy), .long_done(s_long_done), .long_err(s_long_err),
    .stall_cnt(s_stall_cnt)
  );

  typedef struct packed {
    logic [4:0] s0, s1;
    logic       mrw;
    logic [4:0] mwr;
    logic       wbrw;
    logic [4:0] wbwr;
    logic [4:0] id_rs, id_rt;
    logic       uses_rt, id_long, ex_mr;
    logic [4:0] ex_wr;
    logic       lv;
    logic [4:0] lwr;
    logic [2:0] llat;
    logic [1:0] fen, fsel;
    logic       stall, busy, done, err;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s row=%0d got=%0h want=%0h", nm, idx, act, want);
    end
  endtask

  task automatic drive(input vec_t v);
    ex_src        = {v.s1, v.s0};
    m_regwrite    = v.mrw;   m_wr  = v.mwr;
    wb_regwrite   = v.wbrw;  wb_wr = v.wbwr;
    id_rs         = v.id_rs; id_rt = v.id_rt;
    id_uses_rt    = v.uses_rt;
    id_long       = v.id_long;
    ex_mem_read   = v.ex_mr; ex_wr = v.ex_wr;
    ex_long_valid = v.lv;    ex_long_wr = v.lwr; ex_long_lat = v.llat;
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(posedge clk); #1;
    drive(v);
    exp_q.push_back(v);
    #3;
    e = exp_q.pop_front();
    chk("fwd_en",    idx, 32'(fwd_en),      32'(e.fen));
    chk("fwd_sel",   idx, 32'(fwd_sel),     32'(e.fsel));
    chk("stall",     idx, 32'(stall),       32'(e.stall));
    chk("bubble",    idx, 32'(bubble),      32'(e.stall));
    chk("long_busy", idx, 32'(long_busy),   32'(e.busy));
    chk("long_done", idx, 32'(long_done),   32'(e.done));
    chk("long_err",  idx, 32'(long_err),    32'(e.err));
    chk("stall_cnt", idx, 32'(stall_cnt),   32'(exp_cnt));
    chk("cnt_sat",   idx, 32'(s_stall_cnt), 32'((exp_cnt > 7) ? 7 : exp_cnt));
    if (e.stall) exp_cnt++;
  endtask

  initial begin
    vec_t v;
    v = '0;
    rst = 1'b0;
    drive(v);

    // forwarding
    v = '0; v.s0 = 5; v.mrw = 1; v.mwr = 5; v.wbrw = 1; v.wbwr = 5; v.fen = 2'b01; tbl.push_back(v);
    v.mrw = 0; v.fsel = 2'b01; tbl.push_back(v);
    v = '0; v.s0 = 3; v.mrw = 1; v.wbrw = 1; tbl.push_back(v);
    v = '0; v.s0 = 7; v.s1 = 9; v.mrw = 1; v.mwr = 9; v.wbrw = 1; v.wbwr = 7;
    v.fen = 2'b11; v.fsel = 2'b01; tbl.push_back(v);
    v = '0; v.s0 = 4; v.s1 = 4; v.mwr = 4; v.wbwr = 4; tbl.push_back(v);
    v = '0; v.s0 = 6; v.s1 = 6; v.mrw = 1; v.mwr = 7; v.wbrw = 1; v.wbwr = 6;
    v.fen = 2'b11; v.fsel = 2'b11; tbl.push_back(v);
    // load-use
    v = '0; v.ex_mr = 1; v.ex_wr = 8; v.id_rt = 8; v.uses_rt = 1; v.id_rs = 2; v.stall = 1; tbl.push_back(v);
    v.ex_mr = 0; v.ex_wr = 0; v.stall = 0; tbl.push_back(v);
    v.ex_mr = 1; v.ex_wr = 8; v.uses_rt = 0; tbl.push_back(v);
    v.id_rs = 8; v.stall = 1; tbl.push_back(v);
    v.ex_wr = 0; v.id_rs = 0; v.id_rt = 0; v.uses_rt = 1; v.stall = 0; tbl.push_back(v);
    v = '0; v.ex_wr = 8; v.id_rs = 8; tbl.push_back(v);
    // long op, latency 3, id_rs depends on it
    v = '0; v.lv = 1; v.lwr = 9; v.llat = 3; v.id_rs = 9; tbl.push_back(v);
    v.lv = 0; v.busy = 1; v.stall = 1;
    for (int i = 0; i < 3; i++) tbl.push_back(v);
    v.busy = 0; v.stall = 0; v.done = 1; tbl.push_back(v);
    v.done = 0; tbl.push_back(v);
    // latency 0 -> one BUSY cycle; structural stall on id_long
    v = '0; v.lv = 1; v.lwr = 10; v.llat = 0; tbl.push_back(v);
    v.lv = 0; v.id_long = 1; v.busy = 1; v.stall = 1; tbl.push_back(v);
    v.busy = 0; v.stall = 0; v.done = 1; tbl.push_back(v);
    v.done = 0; tbl.push_back(v);
    // latency 7 clamped to 4, rt dependency, issue while busy, reissue in DONE
    v = '0; v.lv = 1; v.lwr = 12; v.llat = 7; v.id_rt = 12; v.uses_rt = 1; tbl.push_back(v);
    v.lv = 0; v.busy = 1; v.stall = 1; tbl.push_back(v);
    v.lv = 1; v.lwr = 3; v.llat = 1; tbl.push_back(v);
    v.lv = 0; v.err = 1; tbl.push_back(v);
    tbl.push_back(v);
    v.busy = 0; v.stall = 0; v.done = 1; v.lv = 1; v.lwr = 13; v.llat = 2;
    v.id_rs = 13; v.id_rt = 0; v.uses_rt = 0; tbl.push_back(v);
    v.lv = 0; v.done = 0; v.busy = 1; v.stall = 1; tbl.push_back(v);
    tbl.push_back(v);
    v.busy = 0; v.stall = 0; v.done = 1; tbl.push_back(v);
    v.done = 0; tbl.push_back(v);

    #3;
    chk("rst_busy", -1, 32'(long_busy), 0);
    chk("rst_done", -1, 32'(long_done), 0);
    chk("rst_err",  -1, 32'(long_err),  0);
    chk("rst_cnt",  -1, 32'(stall_cnt), 0);
    chk("rst_stall",-1, 32'(stall),     0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // async reset in the middle of BUSY
    @(posedge clk); #1;
    v = '0; v.lv = 1; v.lwr = 9; v.llat = 4; v.id_rs = 9; drive(v);
    @(posedge clk); #1;
    ex_long_valid = 1'b0;
    #3;
    chk("mid_busy",  100, 32'(long_busy), 1);
    chk("mid_stall", 100, 32'(stall),     1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy",  101, 32'(long_busy),   0);
    chk("arst_done",  101, 32'(long_done),   0);
    chk("arst_err",   101, 32'(long_err),    0);
    chk("arst_cnt",   101, 32'(stall_cnt),   0);
    chk("arst_cnt_s", 101, 32'(s_stall_cnt), 0);
    chk("arst_stall", 101, 32'(stall),       0);
    ex_mem_read = 1'b1; ex_wr = 5'd9;
    ex_src = 10'd5; m_regwrite = 1'b1; m_wr = 5'd5;
    #1;
    chk("rst_comb_stall", 102, 32'(stall),  1);
    chk("rst_comb_bub",   102, 32'(bubble), 1);
    chk("rst_comb_fwd",   102, 32'(fwd_en), 1);
    @(posedge clk); #2;
    rst = 1'b1;
    v = '0; v.lv = 1; v.llat = 1; drive(v);
    exp_cnt = 0;
    @(posedge clk); #1;
    ex_long_valid = 1'b0;
    #3;
    chk("post_rst_busy", 103, 32'(long_busy), 1);
    chk("post_rst_cnt",  103, 32'(stall_cnt), 0);
    chk("post_rst_err",  103, 32'(long_err),  0);
    @(posedge clk); #4;
    chk("post_rst_done", 104, 32'(long_done), 1);
    chk("post_rst_idle", 104, 32'(long_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
